// File: rtl/piradip_stream_to_register.sv
// Stream-to-register bridge: inbound stream beats are queued in a FIFO that
// software drains through a data (pop) register, with a status/control
// register for occupancy, flush, underflow and interrupt enable.
module piradip_stream_to_register #(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned REGISTER_ADDR_BITS = 8,
    parameter int unsigned DATA_REG_NO        = 0,
    parameter int unsigned STATUS_REG_NO      = 1,
    parameter int unsigned DEPTH              = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          wren,
    input  logic [REGISTER_ADDR_BITS-1:0] wreg_no,
    input  logic [DATA_WIDTH-1:0]         wreg_data,
    input  logic [DATA_WIDTH/8-1:0]       wstrb,
    input  logic                          rden,
    input  logic [REGISTER_ADDR_BITS-1:0] rreg_no,
    output logic [DATA_WIDTH-1:0]         rreg_data,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic [DATA_WIDTH-1:0]         s_tdata,
    input  logic                          s_tlast,
    output logic                          irq
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [REGISTER_ADDR_BITS-1:0] DATA_ADDR = REGISTER_ADDR_BITS'(DATA_REG_NO);
    localparam logic [REGISTER_ADDR_BITS-1:0] STAT_ADDR = REGISTER_ADDR_BITS'(STATUS_REG_NO);

    // Each entry is {tlast, tdata}
    logic [DATA_WIDTH:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             irq_en_q, irq_en_d;
    logic             underflow_q, underflow_d;
    logic             rdy_q, rdy_d;
    logic             irq_q, irq_d;

    logic                  not_empty;
    logic [DATA_WIDTH:0]   head;
    logic                  head_last;
    logic                  data_rd, stat_rd, stat_wr;
    logic                  push, pop, flush, underflow_set;
    logic [DATA_WIDTH-1:0] status_word;
    logic                  unused_bits;

    assign s_tready    = rdy_q;
    assign irq         = irq_q;
    assign not_empty   = (count_q != '0);
    assign head        = mem[rd_ptr_q];
    assign head_last   = head[DATA_WIDTH] & not_empty;
    assign unused_bits = ^{wreg_data, wstrb};

    assign data_rd       = rden && (rreg_no == DATA_ADDR);
    assign stat_rd       = rden && (rreg_no == STAT_ADDR);
    assign stat_wr       = wren && (wreg_no == STAT_ADDR) && wstrb[0];
    assign flush         = stat_wr && wreg_data[4];
    assign push          = s_tvalid && rdy_q;
    assign pop           = data_rd && not_empty;
    assign underflow_set = data_rd && !not_empty;

    assign status_word = DATA_WIDTH'({16'(count_q), 11'd0, 1'b0, underflow_q,
                                      head_last, irq_en_q, not_empty});

    // Combinational register read mux; unmapped numbers read as zero
    always_comb begin
        rreg_data = '0;
        if (rreg_no == DATA_ADDR) begin
            rreg_data = not_empty ? head[DATA_WIDTH-1:0] : '0;
        end else if (rreg_no == STAT_ADDR) begin
            rreg_data = status_word;
        end
    end

    // Next-state for pointers, occupancy and control flags; flush wins over push/pop
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        irq_en_d    = irq_en_q;
        underflow_d = underflow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end

        if (stat_wr) irq_en_d = wreg_data[1];

        if (underflow_set)  underflow_d = 1'b1;
        else if (stat_rd)   underflow_d = 1'b0;

        rdy_d = (count_d != FULL_CNT);
        irq_d = irq_en_q && not_empty;
    end

    // Control state registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            irq_en_q    <= 1'b0;
            underflow_q <= 1'b0;
            rdy_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            irq_en_q    <= irq_en_d;
            underflow_q <= underflow_d;
            rdy_q       <= rdy_d;
            irq_q       <= irq_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr_q] <= {s_tlast, s_tdata};
    end

endmodule
